// File: rtl/spi_controller_if.sv
// Request handshake and serial-line bundle for spi_controller.
// master = request source (host/sequencer), slave = the controller itself.
interface spi_controller_if;
  logic       req_valid;
  logic       req_ready;
  logic [6:0] req_addr;
  logic [7:0] req_data;
  logic       busy;
  logic       done;
  logic       SCLK;
  logic       nCS;
  logic       COPI;

  modport master (
    output req_valid, req_addr, req_data,
    input  req_ready, busy, done, SCLK, nCS, COPI
  );

  modport slave (
    input  req_valid, req_addr, req_data,
    output req_ready, busy, done, SCLK, nCS, COPI
  );
endinterface

// File: rtl/spi_controller.sv
// SPI mode-0 initiator sending 16-bit {1, addr[6:0], data[7:0]} write frames, MSB first.
// Optional 4-entry request FIFO enabled by defining SPI_CTRL_REQ_FIFO_EN.
module spi_controller #(
  parameter int CLK_DIV    = 4,
  parameter int GAP_CYCLES = 8
) (
  input logic             clk,
  input logic             rst,
  spi_controller_if.slave bus
);

  localparam int HW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int GW = $clog2(GAP_CYCLES + 1);
  localparam logic [HW-1:0] HMAX = HW'(CLK_DIV - 1);
  localparam logic [GW-1:0] GMAX = GW'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, LEAD, SHIFT, GAP} state_t;

  state_t        state;
  logic [HW-1:0] half_cnt;
  logic [4:0]    bit_cnt;
  logic [GW-1:0] gap_cnt;
  logic [15:0]   shreg;
  logic          sclk_r, ncs_r, copi_r, busy_r, done_r;

  logic          start;
  logic [6:0]    start_addr;
  logic [7:0]    start_data;

`ifdef SPI_CTRL_REQ_FIFO_EN
  logic [14:0] fifo_mem [4];
  logic [1:0]  wr_ptr, rd_ptr;
  logic [2:0]  occ;
  logic        push, pop;

  assign bus.req_ready = !rst && (occ != 3'd4);
  assign push          = bus.req_valid && bus.req_ready;
  assign pop           = (state == IDLE) && (occ != 3'd0);
  assign start         = pop;
  assign start_addr    = fifo_mem[rd_ptr][14:8];
  assign start_data    = fifo_mem[rd_ptr][7:0];
  assign bus.busy      = busy_r || (occ != 3'd0);

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= {bus.req_addr, bus.req_data};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 2'd1;
      if (pop)  rd_ptr <= rd_ptr + 2'd1;
      case ({push, pop})
        2'b10:   occ <= occ + 3'd1;
        2'b01:   occ <= occ - 3'd1;
        default: occ <= occ;
      endcase
    end
  end
`else
  assign bus.req_ready = !rst && (state == IDLE);
  assign start         = bus.req_valid && bus.req_ready;
  assign start_addr    = bus.req_addr;
  assign start_data    = bus.req_data;
  assign bus.busy      = busy_r;
`endif

  // SCLK itself marks the phase: a half-period ending with SCLK high is a falling
  // edge (advance COPI), ending low is a rising edge or, after bit 0, the frame end.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      half_cnt <= '0;
      bit_cnt  <= '0;
      gap_cnt  <= '0;
      shreg    <= '0;
      sclk_r   <= 1'b0;
      ncs_r    <= 1'b1;
      copi_r   <= 1'b0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
    end else begin
      done_r <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            state    <= LEAD;
            shreg    <= {1'b1, start_addr, start_data};
            ncs_r    <= 1'b0;
            copi_r   <= 1'b1;
            busy_r   <= 1'b1;
            half_cnt <= '0;
          end
        end
        LEAD: begin
          if (half_cnt == HMAX) begin
            half_cnt <= '0;
            bit_cnt  <= '0;
            sclk_r   <= 1'b1;
            state    <= SHIFT;
          end else begin
            half_cnt <= half_cnt + HW'(1);
          end
        end
        SHIFT: begin
          if (half_cnt != HMAX) begin
            half_cnt <= half_cnt + HW'(1);
          end else begin
            half_cnt <= '0;
            if (sclk_r) begin
              sclk_r <= 1'b0;
              if (bit_cnt != 5'd15) begin
                shreg  <= shreg << 1;
                copi_r <= shreg[14];
              end
            end else if (bit_cnt == 5'd15) begin
              state   <= GAP;
              bit_cnt <= '0;
              gap_cnt <= '0;
              ncs_r   <= 1'b1;
              copi_r  <= 1'b0;
              done_r  <= 1'b1;
            end else begin
              sclk_r  <= 1'b1;
              bit_cnt <= bit_cnt + 5'd1;
            end
          end
        end
        GAP: begin
          if (gap_cnt == GMAX) begin
            gap_cnt <= '0;
            busy_r  <= 1'b0;
            state   <= IDLE;
          end else begin
            gap_cnt <= gap_cnt + GW'(1);
          end
        end
      endcase
    end
  end

  assign bus.SCLK = sclk_r;
  assign bus.nCS  = ncs_r;
  assign bus.COPI = copi_r;
  assign bus.done = done_r;

endmodule

// File: tb/tb_spi_controller.sv
// Self-checking bench for spi_controller: SPI peripheral model plus frame/timing reference.
module tb_spi_controller;

  localparam int CD  = 4;
  localparam int GAP = 8;
`ifdef SPI_CTRL_REQ_FIFO_EN
  localparam int P    = 1;
  localparam bit FIFO = 1'b1;
`else
  localparam int P    = 0;
  localparam bit FIFO = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  spi_controller_if bus ();

  spi_controller #(.CLK_DIV(CD), .GAP_CYCLES(GAP)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Peripheral model: shift COPI on SCLK rise while selected, commit on nCS rise.
  logic [7:0]  pregs    [128];
  logic [7:0]  exp_regs [128];
  logic [15:0] frames [$];
  int          nbits_q [$];
  logic [15:0] msh = '0;
  int          mnb = 0;
  int          stab_err = 0;
  logic        prev_sclk = 1'b0, prev_ncs = 1'b1, prev_copi = 1'b0;

  always @(negedge clk) begin
    if (rst) begin
      msh = '0;
      mnb = 0;
    end else begin
      if (!bus.nCS && bus.SCLK && !prev_sclk) begin
        msh = {msh[14:0], bus.COPI};
        mnb++;
      end
      if (!bus.nCS && bus.SCLK && prev_sclk && bus.COPI !== prev_copi) stab_err++;
      if (bus.nCS && !prev_ncs) begin
        frames.push_back(msh);
        nbits_q.push_back(mnb);
        if (mnb == 16 && msh[15]) pregs[msh[14:8]] = msh[7:0];
        msh = '0;
        mnb = 0;
      end
    end
    prev_sclk = bus.SCLK;
    prev_ncs  = bus.nCS;
    prev_copi = bus.COPI;
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout observed=cycle %0d required=finish", cyc);
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_regs();
    for (int i = 0; i < 128; i++) begin
      pregs[i]    = 8'h00;
      exp_regs[i] = 8'h00;
    end
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.req_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  // Called at a negedge; returns at the negedge of the accept cycle (t = that cycle).
  task automatic do_req(input logic [6:0] a, input logic [7:0] d, output int t);
    bus.req_valid = 1'b1;
    bus.req_addr  = a;
    bus.req_data  = d;
    t = -1;
    for (int i = 0; i < 400; i++) begin
      if (bus.req_ready) begin
        t = cyc;
        break;
      end
      @(negedge clk);
    end
    check("accept_within_bound", (t >= 0), 1);
  endtask

  // Walks one full frame after accept at cycle t, checking every cycle against the
  // expected timeline, then compares the frame the peripheral model captured.
  task automatic run_frame(input int t, input logic [15:0] exp_frame, input bit hold,
                           input logic [6:0] na, input logic [7:0] nd);
    int ncs_err = 0, done_err = 0, busy_err = 0, rdy_err = 0, cyc_err = 0;
    int lo_end = P + 33 * CD;
    int last   = lo_end + GAP + 1;
    logic [15:0] f;
    int nb;
    for (int k = 1; k <= last; k++) begin
      @(negedge clk);
      if (k == 1) begin
        bus.req_valid = hold;
        bus.req_addr  = na;
        bus.req_data  = nd;
      end
      if (cyc != t + k) cyc_err++;
      if (bus.nCS  !== !(k >= 1 + P && k <= lo_end)) ncs_err++;
      if (bus.done !== (k == lo_end + 1))            done_err++;
      if (bus.busy !== (k < last))                   busy_err++;
      if (bus.req_ready !== (FIFO || k == last))     rdy_err++;
    end
    check("cycle_alignment", cyc_err, 0);
    check("ncs_window", ncs_err, 0);
    check("done_pulse", done_err, 0);
    check("busy_window", busy_err, 0);
    check("ready_return", rdy_err, 0);
    check("copi_stable_high", stab_err, 0);
    check("frame_count", frames.size(), 1);
    if (frames.size() > 0) begin
      f  = frames.pop_front();
      nb = nbits_q.pop_front();
      check("frame_value", f, exp_frame);
      check("sclk_rises", nb, 16);
    end
  endtask

  initial begin
    int t, t2;
    logic [6:0] a, a2;
    logic [7:0] d, d2;
    logic [7:0] snap [128];
    int diff;

    bus.req_valid = 1'b0;
    bus.req_addr  = '0;
    bus.req_data  = '0;
    clear_regs();

    // Reset state
    @(negedge clk);
    check("rst_ncs", bus.nCS, 1);
    check("rst_sclk", bus.SCLK, 0);
    check("rst_copi", bus.COPI, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_ready", bus.req_ready, 0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_ready", bus.req_ready, 1);

    // Single write 0x04/0xA5 -> 0x84A5, inputs scrambled on T+1
    do_req(7'h04, 8'hA5, t);
    run_frame(t, 16'h84A5, 1'b0, 7'h7B, 8'h5A);
    exp_regs[4] = 8'hA5;
    check("reg_after_single", pregs[4], exp_regs[4]);

    // Reset mid-SHIFT during bit 7
    for (int i = 0; i < 128; i++) snap[i] = pregs[i];
    do_req(7'h55, 8'hC3, t);
    for (int k = 1; k <= P + CD + 8 * 8 + 2; k++) begin
      @(negedge clk);
      if (k == 1) bus.req_valid = 1'b0;
    end
    check("pre_rst_ncs_low", bus.nCS, 0);
    rst = 1'b1;
    #1;
    check("midrst_ncs", bus.nCS, 1);
    check("midrst_sclk", bus.SCLK, 0);
    check("midrst_copi", bus.COPI, 0);
    check("midrst_busy", bus.busy, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    diff = 0;
    for (int i = 0; i < 128; i++) if (pregs[i] !== snap[i]) diff++;
    check("regs_unchanged_by_abort", diff, 0);
    check("no_partial_frame", frames.size(), 0);
    do_req(7'h01, 8'h3C, t);
    run_frame(t, 16'h813C, 1'b0, 7'h00, 8'h00);
    exp_regs[1] = 8'h3C;
    check("reg_after_reset_frame", pregs[1], exp_regs[1]);

`ifndef SPI_CTRL_REQ_FIFO_EN
    // Back-to-back with req_valid held high
    a  = 7'($urandom_range(0, 127));
    d  = 8'($urandom);
    a2 = 7'($urandom_range(0, 127));
    d2 = 8'($urandom);
    @(negedge clk);
    do_req(a, d, t);
    run_frame(t, {1'b1, a, d}, 1'b1, a2, d2);
    do_req(a2, d2, t2);
    check("b2b_spacing", t2 - t, 33 * CD + GAP + 1);
    run_frame(t2, {1'b1, a2, d2}, 1'b0, 7'h00, 8'h00);
    exp_regs[a] = d;
    exp_regs[a2] = d2;
    check("b2b_reg_second", pregs[a2], exp_regs[a2]);
`endif

    // Randomized frames with idle spacing and scrambled post-accept inputs
    for (int n = 0; n < 6; n++) begin
      a = 7'($urandom_range(0, 127));
      d = 8'($urandom);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      do_req(a, d, t);
      run_frame(t, {1'b1, a, d}, 1'b0, 7'($urandom), 8'($urandom));
      exp_regs[a] = d;
      check("rand_reg", pregs[a], exp_regs[a]);
    end

    // End-to-end register image
    apply_reset();
    clear_regs();
    do_req(7'h00, 8'hFF, t);
    run_frame(t, 16'h80FF, 1'b0, 7'h00, 8'h00);
    do_req(7'h02, 8'h0F, t);
    run_frame(t, 16'h820F, 1'b0, 7'h00, 8'h00);
    do_req(7'h04, 8'h80, t);
    run_frame(t, 16'h8480, 1'b0, 7'h00, 8'h00);
    check("en_reg_out_7_0", pregs[0], 8'hFF);
    check("en_reg_out_15_8", pregs[1], 8'h00);
    check("en_reg_pwm_7_0", pregs[2], 8'h0F);
    check("en_reg_pwm_15_8", pregs[3], 8'h00);
    check("pwm_duty_cycle", pregs[4], 8'h80);

`ifdef SPI_CTRL_REQ_FIFO_EN
    // FIFO burst: six consecutive offers, the sixth finds the FIFO full
    begin
      logic [15:0] sent [$];
      int busy_err = 0;
      int waited = 0;
      for (int i = 0; i < 6; i++) begin
        a = 7'($urandom_range(0, 127));
        d = 8'($urandom);
        bus.req_valid = 1'b1;
        bus.req_addr  = a;
        bus.req_data  = d;
        check("fifo_ready_offer", bus.req_ready, (i < 5));
        while (!bus.req_ready && waited < 400) begin
          @(negedge clk);
          waited++;
          if (!bus.busy) busy_err++;
        end
        sent.push_back({1'b1, a, d});
        @(negedge clk);
        if (!bus.busy) busy_err++;
      end
      bus.req_valid = 1'b0;
      waited = 0;
      while (frames.size() < 6 && waited < 1200) begin
        @(negedge clk);
        waited++;
        if (frames.size() < 6 && !bus.busy) busy_err++;
      end
      check("fifo_all_frames", frames.size(), 6);
      check("fifo_busy_held", busy_err, 0);
      while (frames.size() > 0 && sent.size() > 0) begin
        check("fifo_order", frames.pop_front(), sent.pop_front());
        void'(nbits_q.pop_front());
      end
      repeat (GAP + 2) @(negedge clk);
      check("fifo_idle_after", bus.busy, 0);
    end
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
